ping_pong_mem: RTL and testbench
================================

PING_PONG_MEM -- requirements
Module: ping_pong_mem

Interface
REQ-001 Parameter DW, 16, bits per channel value.
REQ-002 Parameter WCH, 64, channels per write word.
REQ-003 Parameter RCH, 16, channels per read word.
REQ-004 Parameter DEPTH, 4096, pixel locations per bank.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  rising-edge clock for all logic.
REQ-007 rst  input  1  asynchronous active-low reset.
REQ-008 inputsize  input  32  pixels per frame; 3025 (55x55) in the current pipeline.
REQ-009 wren  input  1  write enable.
REQ-010 rden  input  1  read enable.
REQ-011 address1  input  32  0-based write pixel index.
REQ-012 address2  input  32  read address: [1:0] channel group, [31:2] pixel index.
REQ-013 datain  input  DW*WCH (1024)  one pixel; channel c at bits [c*16 +: 16].
REQ-014 dataout  output  DW*RCH (256)  16 channels; lane k at bits [k*16 +: 16].
REQ-015 wrbank  output  1  bank currently being written; the other bank is read.

Function
REQ-016 Storage SHALL be two banks (bank 0, bank 1), each DEPTH x 1024 bits; contents SHALL NOT be cleared by reset.
REQ-017 On rising clk with wren=1 and address1 < inputsize and address1 < DEPTH, datain SHALL be written to bank wrbank at index address1.
REQ-018 Any other write attempt SHALL be ignored, with no state change.
REQ-019 A valid write with address1 = inputsize-1 SHALL complete the frame and toggle wrbank at that clock edge.
REQ-020 After the toggle, the just-filled bank SHALL become the read bank.
REQ-021 Reads SHALL always use bank ~wrbank.
REQ-022 Read decode: g = address2[1:0], p = address2[31:2]; lane k SHALL hold channel 16*g+k of pixel p.
REQ-023 With rden=1, dataout SHALL be registered and valid one clock after address2 is presented (1-cycle latency).
REQ-024 With rden=1 and (p >= inputsize or p >= DEPTH), dataout SHALL be registered as all zeros.
REQ-025 With rden=0, dataout SHALL hold its last value.
REQ-026 Write and read in the same cycle SHALL be independent: different banks, no stall, no priority.
REQ-027 If a bank swap and a read occur on the same edge, the read SHALL use the pre-edge read bank.
REQ-028 Reads take no part in the swap decision; rereading a bank any number of times SHALL be legal.
REQ-029 inputsize is sampled every cycle; the frame-complete test SHALL use its current value.
REQ-030 inputsize = 0 SHALL disable all writes and swaps.

Reset
REQ-031 While rst=0: dataout SHALL be 0 and wrbank SHALL be 0 (bank 1 is the read bank).
REQ-032 Both take effect asynchronously on reset assertion.
REQ-033 Reset mid-frame SHALL abandon the frame: wrbank returns to 0 and the next frame restarts at any address1.
REQ-034 Writes and reads SHALL be ignored while rst=0.

Verification
REQ-035 Full frame, inputsize=3025: write pixel p with channel c = p*64+c for p=0..3024 -> wrbank 0 then 1 after write 3024.
REQ-036 Read-back of that frame: read address2=(10<<2)|2 -> next cycle, lane k = 640+32+k.
REQ-037 Out-of-range read: address2=(3025<<2) -> dataout all zeros next cycle.
REQ-038 rden=0 -> dataout unchanged.
REQ-039 Ping-pong concurrency: second frame written (values +0x1000) while frame 1 is read at address2 = 0..12099.
REQ-040 During that overlap, reads SHALL return frame-1 data only; after write 3024 of frame 2, wrbank = 0 and reads return frame-2 data.
REQ-041 Ignored writes: wren=1 with address1=3025 -> no swap, no change to memory.
REQ-042 Reset mid-operation: rst=0 asynchronously between edges after 100 writes -> dataout=0 and wrbank=0 immediately.

Source files
------------

// File: rtl/ping_pong_mem.sv
// Double-buffered pixel store: one bank takes a frame of full-width pixels while
// the other bank is read back one channel group at a time; banks swap per frame.
module ping_pong_mem #(
   parameter int DW    = 16,
   parameter int WCH   = 64,
   parameter int RCH   = 16,
   parameter int DEPTH = 4096
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         inputsize,
   input  logic                wren,
   input  logic                rden,
   input  logic [31:0]         address1,
   input  logic [31:0]         address2,
   input  logic [DW*WCH-1:0]   datain,
   output logic [DW*RCH-1:0]   dataout,
   output logic                wrbank
);

   localparam int AW = $clog2(DEPTH);
   localparam int WW = DW * WCH;
   localparam int RW = DW * RCH;
   localparam int GW = $clog2(WCH / RCH);

   // Contents deliberately have no reset; only the bank pointer and output do.
   logic [WW-1:0] r_mem [2][DEPTH];
   logic          r_wrbank;
   logic [RW-1:0] r_dataout;

   logic          w_wr_ok;
   logic          w_frame_done;
   logic [31:0]   w_rd_pix;
   logic [GW-1:0] w_rd_grp;
   logic          w_rd_ok;
   logic [WW-1:0] w_rd_word;
   logic [RW-1:0] w_rd_lanes;

   assign w_wr_ok      = rst && wren && (address1 < inputsize) && (address1 < 32'(DEPTH));
   assign w_frame_done = w_wr_ok && (address1 == inputsize - 32'd1);

   assign w_rd_pix   = {{GW{1'b0}}, address2[31:GW]};
   assign w_rd_grp   = address2[GW-1:0];
   assign w_rd_ok    = (w_rd_pix < inputsize) && (w_rd_pix < 32'(DEPTH));
   assign w_rd_word  = r_mem[~r_wrbank][w_rd_pix[AW-1:0]];
   assign w_rd_lanes = w_rd_word[w_rd_grp*RW +: RW];

   always_ff @(posedge clk) begin
      if (w_wr_ok) begin
         r_mem[r_wrbank][address1[AW-1:0]] <= datain;
      end
   end

   // The last pixel of a frame flips the pointer on the same edge it is stored.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wrbank <= 1'b0;
      end else if (w_frame_done) begin
         r_wrbank <= ~r_wrbank;
      end
   end

   // Read timing: address2 sampled with rden=1 on an edge gives dataout valid
   // after that edge; rden=0 holds dataout. The read bank is the pre-edge one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_dataout <= '0;
      end else if (rden) begin
         r_dataout <= w_rd_ok ? w_rd_lanes : '0;
      end
   end

   assign dataout = r_dataout;
   assign wrbank  = r_wrbank;

endmodule

// File: tb/tb_ping_pong_mem.sv
// Randomized scoreboard bench for ping_pong_mem: a frame-level model predicts
// dataout and wrbank for every driven cycle; a monitor compares after each edge.
module tb_ping_pong_mem;

   localparam int DW    = 16;
   localparam int WCH   = 64;
   localparam int RCH   = 16;
   localparam int DEPTH = 4096;
   localparam int WW    = DW * WCH;
   localparam int RW    = DW * RCH;
   localparam int EW    = RW + 2;

   logic          clk;
   logic          rst;
   logic [31:0]   inputsize;
   logic          wren;
   logic          rden;
   logic [31:0]   address1;
   logic [31:0]   address2;
   logic [WW-1:0] datain;
   logic [RW-1:0] dataout;
   logic          wrbank;

   ping_pong_mem #(.DW(DW), .WCH(WCH), .RCH(RCH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .inputsize (inputsize),
      .wren      (wren),
      .rden      (rden),
      .address1  (address1),
      .address2  (address2),
      .datain    (datain),
      .dataout   (dataout),
      .wrbank    (wrbank)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // reference model: two frame buffers, a bank pointer and the held output
   logic [WW-1:0] m_mem   [2][DEPTH];
   bit            m_known [2][DEPTH];
   bit            m_wb;
   logic [RW-1:0] m_dout;
   bit            m_care;

   // entry = {dataout_known, wrbank, dataout}
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] mon_e;
   int            n_checks;
   int            n_errors;

   function automatic logic [WW-1:0] make_px(input int p, input int off);
      logic [WW-1:0] px;
      for (int c = 0; c < WCH; c++) px[c*DW +: DW] = 16'(p*64 + c + off);
      return px;
   endfunction

   function automatic logic [RW-1:0] make_lanes(input int base);
      logic [RW-1:0] v;
      for (int k = 0; k < RCH; k++) v[k*DW +: DW] = 16'(base + k);
      return v;
   endfunction

   task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // driver: called at a negedge, applies one cycle of inputs, predicts the
   // post-edge outputs and returns at the following negedge
   task automatic do_cycle(input bit we, input logic [31:0] a1, input logic [WW-1:0] d,
                           input bit re, input logic [31:0] a2);
      int pix;
      int grp;
      wren     = we;
      address1 = a1;
      datain   = d;
      rden     = re;
      address2 = a2;
      if (re) begin
         pix = int'(a2 >> 2);
         grp = int'(a2 & 32'd3);
         if ((a2 >> 2) < inputsize && (a2 >> 2) < DEPTH) begin
            m_care = m_known[!m_wb][pix];
            m_dout = m_mem[!m_wb][pix][grp*RW +: RW];
         end else begin
            m_care = 1'b1;
            m_dout = '0;
         end
      end
      if (we && a1 < inputsize && a1 < DEPTH) begin
         m_mem[m_wb][a1]   = d;
         m_known[m_wb][a1] = 1'b1;
         if (a1 == inputsize - 1) m_wb = !m_wb;
      end
      exp_q.push_back({m_care, m_wb, m_dout});
      @(negedge clk);
   endtask

   // monitor
   always @(posedge clk) begin
      if (rst && exp_q.size() > 0) begin
         #1;
         mon_e = exp_q.pop_front();
         check("wrbank", RW'(wrbank), RW'(mon_e[RW]));
         if (mon_e[RW+1]) check("dataout", dataout, mon_e[RW-1:0]);
      end
   end

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      rst       = 1'b0;
      wren      = 1'b0;
      rden      = 1'b0;
      address1  = '0;
      address2  = '0;
      datain    = '0;
      inputsize = 32'd3025;
      m_wb      = 1'b0;
      m_dout    = '0;
      m_care    = 1'b1;

      repeat (3) @(negedge clk);
      check("reset_dataout", dataout, '0);
      check("reset_wrbank", RW'(wrbank), '0);
      rst = 1'b1;
      @(negedge clk);

      // frame 1 with idle cycles and reads of the (unwritten) read bank
      for (int p = 0; p < 3025; p++) begin
         if ($urandom_range(0, 7) == 0)
            do_cycle(1'b0, $urandom, make_px(p, 7), 1'($urandom_range(0, 1)), $urandom);
         do_cycle(1'b1, 32'(p), make_px(p, 0), 1'($urandom_range(0, 1)), $urandom);
      end
      check("frame1_swap", RW'(wrbank), RW'(1));

      do_cycle(1'b0, '0, '0, 1'b1, (32'd10 << 2) | 32'd2);
      check("readback_p10_g2", dataout, make_lanes(640 + 32));

      do_cycle(1'b0, '0, '0, 1'b1, 32'd3025 << 2);
      check("read_out_of_range", dataout, '0);

      do_cycle(1'b0, '0, '0, 1'b1, (32'd10 << 2) | 32'd2);
      for (int i = 0; i < 3; i++) do_cycle(1'b0, '0, '0, 1'b0, 32'($urandom_range(0, 12099)));
      check("rden0_hold", dataout, make_lanes(640 + 32));

      do_cycle(1'b1, 32'd3025, make_px(1, 99), 1'b0, '0);
      do_cycle(1'b1, 32'd4096, make_px(2, 99), 1'b0, '0);
      do_cycle(1'b1, 32'hFFFF_FFFF, make_px(3, 99), 1'b0, '0);
      check("ignored_write_no_swap", RW'(wrbank), RW'(1));

      // frame 2 written while frame 1 is streamed out
      for (int i = 0; i < 12100; i++)
         do_cycle((i % 4) == 0, 32'(i / 4), make_px(i / 4, 'h1000), 1'b1, 32'(i));
      check("frame2_swap", RW'(wrbank), '0);
      do_cycle(1'b0, '0, '0, 1'b1, (32'd10 << 2) | 32'd2);
      check("readback_frame2", dataout, make_lanes(640 + 'h1000 + 32));

      // short frame to move the pointer to 1, then reset part-way into the next
      inputsize = 32'd200;
      for (int p = 0; p < 200; p++)
         do_cycle(1'b1, 32'(p), make_px(p, 'h2000), 1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 799)));
      inputsize = 32'd3025;
      for (int p = 0; p < 100; p++)
         do_cycle(1'b1, 32'(p), make_px(p, 'h3000), 1'b1, 32'($urandom_range(0, 12099)));
      do_cycle(1'b0, '0, '0, 1'b1, 32'd5 << 2);
      check("pre_reset_wrbank", RW'(wrbank), RW'(1));
      #2;
      rst = 1'b0;
      #1;
      check("async_reset_dataout", dataout, '0);
      check("async_reset_wrbank", RW'(wrbank), '0);
      m_wb   = 1'b0;
      m_dout = '0;
      m_care = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      // new frame may start at any address after the abandoned one
      inputsize = 32'd50;
      for (int p = 10; p < 50; p++)
         do_cycle(1'b1, 32'(p), make_px(p, 'h4000), 1'b1, 32'($urandom_range(0, 210)));
      check("post_reset_swap", RW'(wrbank), RW'(1));

      // random traffic with small, changing frame sizes (including zero)
      for (int i = 0; i < 3000; i++) begin
         if ((i % 250) == 0) inputsize = 32'($urandom_range(0, 6));
         do_cycle(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0) ? 32'($urandom) : 32'($urandom_range(0, int'(inputsize) + 2)),
                  make_px($urandom_range(0, 4095), $urandom_range(0, 65535)),
                  1'($urandom_range(0, 1)),
                  {30'($urandom_range(0, int'(inputsize) + 1)), 2'($urandom_range(0, 3))});
      end

      repeat (2) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL exp_q_drain: got %0d pending expected 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
